// File: rtl/multiport_register_file_if.sv
`default_nettype none
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif
// ============================================================================
//  Module      : multiport_register_file_if
//  Description : Port bundle for the multiport register file: write ports,
//                read ports, issue reservation and scoreboard status.
//  Revision    : 1.0  initial release
// ============================================================================
interface multiport_register_file_if #(
  parameter int REGISTER_COUNT = 32,
  parameter int WIDTH          = `BIT_COUNT,
  parameter int READ_PORTS     = 2,
  parameter int WRITE_PORTS    = 1
);
  localparam int c_addr_w = $clog2(REGISTER_COUNT);

  logic [WRITE_PORTS-1:0]                 WriteEn;
  logic [WRITE_PORTS-1:0][c_addr_w-1:0]   rdAdr;
  logic [WRITE_PORTS-1:0][WIDTH-1:0]      Rd;
  logic [READ_PORTS-1:0][c_addr_w-1:0]    rsAdr;
  logic [READ_PORTS-1:0][WIDTH-1:0]       Rs;
  logic [READ_PORTS-1:0]                  RsBusy;
  logic                                   IssueEn;
  logic [c_addr_w-1:0]                    issueAdr;
  logic [c_addr_w:0]                      PendingCount;

  modport master (
    output WriteEn, rdAdr, Rd, rsAdr, IssueEn, issueAdr,
    input  Rs, RsBusy, PendingCount
  );

  modport slave (
    input  WriteEn, rdAdr, Rd, rsAdr, IssueEn, issueAdr,
    output Rs, RsBusy, PendingCount
  );
endinterface
`default_nettype wire

// File: rtl/multiport_register_file.sv
`default_nettype none
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif
// ============================================================================
//  Module      : multiport_register_file
//  Description : N-read / M-write integer register file with x0 hardwired to
//                zero, optional write-to-read bypass and pending-write scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module multiport_register_file #(
  parameter int REGISTER_COUNT = 32,
  parameter int WIDTH          = `BIT_COUNT,
  parameter int READ_PORTS     = 2,
  parameter int WRITE_PORTS    = 1,
  parameter int BYPASS         = 1
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  multiport_register_file_if.slave  bus
);
  localparam int c_addr_w = $clog2(REGISTER_COUNT);
  localparam int c_cnt_w  = c_addr_w + 1;

  logic [WIDTH-1:0]                r_regs [REGISTER_COUNT];
  logic [REGISTER_COUNT-1:0]       r_busy;
  logic [c_cnt_w-1:0]              r_pending;

  logic [REGISTER_COUNT-1:0]       w_wr_hit;
  logic [WIDTH-1:0]                w_wr_data [REGISTER_COUNT];
  logic [REGISTER_COUNT-1:0]       w_issue_hit;
  logic [REGISTER_COUNT-1:0]       w_busy_nxt;
  logic [c_cnt_w-1:0]              w_pending_nxt;
  logic [READ_PORTS-1:0][WIDTH-1:0] w_rs;
  logic [READ_PORTS-1:0]           w_rs_busy;

  // Per-register write decode; ascending scan lets the highest-index port win.
  always_comb begin
    w_wr_hit    = '0;
    w_issue_hit = '0;
    for (int r = 0; r < REGISTER_COUNT; r++) begin
      w_wr_data[r] = '0;
      if (r != 0) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (bus.WriteEn[p] && (bus.rdAdr[p] == c_addr_w'(r))) begin
            w_wr_hit[r]  = 1'b1;
            w_wr_data[r] = bus.Rd[p];
          end
        end
        w_issue_hit[r] = bus.IssueEn && (bus.issueAdr == c_addr_w'(r));
      end
    end
  end

  // A same-cycle issue overrides the clear from writeback: it is the younger producer.
  always_comb begin
    w_busy_nxt    = '0;
    w_pending_nxt = '0;
    for (int r = 1; r < REGISTER_COUNT; r++) begin
      w_busy_nxt[r] = w_issue_hit[r] | (r_busy[r] & ~w_wr_hit[r]);
      w_pending_nxt = w_pending_nxt + c_cnt_w'(w_busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REGISTER_COUNT; r++) begin
        r_regs[r] <= '0;
      end
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      for (int r = 0; r < REGISTER_COUNT; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_data[r];
        end
      end
      r_busy    <= w_busy_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // w_wr_hit/w_issue_hit are never set for x0, so the bypass never touches it.
  always_comb begin
    w_rs      = '0;
    w_rs_busy = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      if ((BYPASS != 0) && w_wr_hit[bus.rsAdr[i]]) begin
        w_rs[i] = w_wr_data[bus.rsAdr[i]];
      end else if (bus.rsAdr[i] != '0) begin
        w_rs[i] = r_regs[bus.rsAdr[i]];
      end
      w_rs_busy[i] = r_busy[bus.rsAdr[i]]
                   & ~((BYPASS != 0) & w_wr_hit[bus.rsAdr[i]] & ~w_issue_hit[bus.rsAdr[i]]);
    end
  end

  assign bus.Rs           = w_rs;
  assign bus.RsBusy       = w_rs_busy;
  assign bus.PendingCount = r_pending;

endmodule
`default_nettype wire
